// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle; define MULDIV_DIV_EN to build the divider
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter bit ZERO_SHORTCUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal
);
`ifdef MULDIV_DIV_EN
  localparam bit div_en = 1'b1;
`else
  localparam bit div_en = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] m_q, m_d, wb_data_q, wb_data_d;
  logic [2*XLEN-1:0] acc_q, acc_d, iter, prod;
  logic neg_q, neg_d, skip_q, skip_d, ill_q, ill_d;
  logic done_q, done_d, wb_we_q, wb_we_d, illegal_q, illegal_d;
  logic accept, finish, sa, sb, bz;
  logic [XLEN-1:0] amag, bmag, mul_res, div_res, res;
  logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] rem_sh, diff;
  logic [XLEN-1:0] div_sel;
`endif
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    finish = (state_q == CALC) & (skip_q | (cnt_q == 5'd31));
    state_d = (state_q == IDLE) ? (start ? CALC : IDLE) :
              (state_q == CALC) ? (finish ? DONE : CALC) : IDLE;
  end
  always_comb begin
    busy = state_q != IDLE;
    done = done_q;
    wb_we = wb_we_q;
    wb_rd = wb_rd_q;
    wb_data = wb_data_q;
    illegal = illegal_q;
  end
  always_comb begin
    accept = (state_q == IDLE) & start;
    sa = a[XLEN-1] & (op == 3'd1 | op == 3'd2 | op == 3'd4 | op == 3'd6);
    sb = b[XLEN-1] & (op == 3'd1 | op == 3'd4 | op == 3'd6);
    amag = sa ? -a : a;
    bmag = sb ? -b : b;
    bz = b == '0;
    // Multiply: right-shifting accumulator {partial product, remaining multiplier}
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    iter = {sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    // Divide: {remainder, dividend/quotient}, restoring step
    rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff = rem_sh - {1'b0, m_q};
    if (op_q[2]) iter = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
`endif
    op_d = accept ? op : op_q;
    rd_d = accept ? rd : rd_q;
    m_d = accept ? (op[2] ? bmag : amag) : m_q;
    neg_d = accept ? (op[2] ? (op[1] ? sa : (sa ^ sb) & ~bz) : sa ^ sb) : neg_q;
    skip_d = accept ? op[2] & (~div_en | (bz & ZERO_SHORTCUT)) : skip_q;
    ill_d = accept ? op[2] & ~div_en : ill_q;
    cnt_d = accept ? 5'd0 : (state_q == CALC) ? cnt_q + 5'd1 : cnt_q;
    // The divide-by-zero shortcut preloads the final {remainder, quotient} magnitudes
    acc_d = accept ? (op[2] ? ((bz & ZERO_SHORTCUT) ? {amag, {XLEN{1'b1}}} : {{XLEN{1'b0}}, amag})
                            : {{XLEN{1'b0}}, bmag}) :
            ((state_q == CALC) & ~skip_q) ? iter : acc_q;
    prod = neg_q ? -acc_d : acc_d;
    mul_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_res = '0;
`ifdef MULDIV_DIV_EN
    div_sel = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    div_res = neg_q ? -div_sel : div_sel;
`endif
    res = op_q[2] ? div_res : mul_res;
    done_d = finish;
    wb_we_d = finish & (rd_q != 5'd0) & ~ill_q;
    wb_rd_d = finish ? rd_q : 5'd0;
    wb_data_d = (finish & ~ill_q) ? res : '0;
    illegal_d = finish & ill_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      skip_q <= 1'b0;
      ill_q <= 1'b0;
      done_q <= 1'b0;
      wb_we_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      skip_q <= skip_d;
      ill_q <= ill_d;
      done_q <= done_d;
      wb_we_q <= wb_we_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      illegal_q <= illegal_d;
    end
  end
  always_ff @(posedge clk) begin
    op_q <= op_d;
    rd_q <= rd_d;
    m_q <= m_d;
    neg_q <= neg_d;
    acc_q <= acc_d;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed RV32M ops checked by a queue scoreboard against an arithmetic model
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] rd = '0;
  logic busy, done, wb_we, illegal;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  int n_chk = 0, n_fail = 0, cyc = 0, n_done = 0, nd = 0;
  bit mon_en = 1'b0;
  typedef struct {
    logic [4:0] rd;
    logic [31:0] data;
    logic we;
    logic ill;
    int t;
    int lat;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .busy(busy), .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] d, output logic il, output int lt);
    logic [63:0] xe, ye, p;
    il = 1'b0;
    lt = 33;
    d = '0;
    if (!o[2]) begin
      xe = (o == 3'd1 || o == 3'd2) ? {{32{x[31]}}, x} : {32'd0, x};
      ye = (o == 3'd1) ? {{32{y[31]}}, y} : {32'd0, y};
      p = xe * ye;
      d = (o == 3'd0) ? p[31:0] : p[63:32];
    end else begin
`ifdef MULDIV_DIV_EN
      if (y == 0) begin
        d = o[1] ? x : 32'hFFFFFFFF;
        lt = 2;
      end else if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)
        d = o[1] ? 32'd0 : 32'h80000000;
      else if (!o[0])
        d = o[1] ? $signed(x) % $signed(y) : $signed(x) / $signed(y);
      else
        d = o[1] ? x % y : x / y;
`else
      il = 1'b1;
      lt = 2;
`endif
    end
  endfunction

  task automatic push_exp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
    exp_t e;
    logic [31:0] d;
    logic il;
    int lt;
    model(o, x, y, d, il, lt);
    e.rd = r;
    e.data = d;
    e.ill = il;
    e.we = (r != 0) && !il;
    e.lat = lt;
    e.t = cyc;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
    op = o;
    a = x;
    b = y;
    rd = r;
    start = 1'b1;
    push_exp(o, x, y, r);
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom);
    rd = 5'($urandom);
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    chk("idle_within_bound", busy, 0);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (done) begin
      n_done++;
      chk("sb_has_entry_at_done", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("wb_data", wb_data, mon_e.data);
        chk("wb_rd", wb_rd, mon_e.rd);
        chk("wb_we", wb_we, mon_e.we);
        chk("illegal", illegal, mon_e.ill);
        chk("latency", cyc - mon_e.t, mon_e.lat);
      end
    end else
      chk("wb_zero_when_idle", {wb_we, illegal, wb_rd, wb_data}, 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] o;
    logic [31:0] x, y;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("reset_idle", {busy, done, wb_we, illegal, wb_rd, wb_data}, 0);
      @(negedge clk);
    end
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5); wait_idle();
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1); wait_idle();
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2); wait_idle();
    issue(3'd1, 32'h80000000, 32'h80000000, 5'd3); wait_idle();
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4); wait_idle();
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6); wait_idle();
    issue(3'd5, 32'd123, 32'd0, 5'd7); wait_idle();
    issue(3'd6, 32'hFFFFFF85, 32'd0, 5'd8); wait_idle();
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd9); wait_idle();
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10); wait_idle();
    issue(3'd0, 32'd9, 32'd9, 5'd0); wait_idle();
    nd = n_done;
    op = 3'd0; a = 32'd12345; b = 32'd678; rd = 5'd11; start = 1'b1;
    push_exp(3'd0, 32'd12345, 32'd678, 5'd11);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    start = 1'b0;
    chk("held_start_done_seen", done, 1);
    repeat (5) @(negedge clk);
    chk("held_start_one_completion", n_done - nd, 1);
    chk("held_start_idle", busy, 0);
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = $urandom_range(1, 15);
        default: ;
      endcase
      issue(o, x, y, 5'($urandom_range(0, 31)));
      wait_idle();
    end
    nd = n_done;
`ifdef MULDIV_DIV_EN
    issue(3'd4, 32'd1000, 32'd7, 5'd12);
`else
    issue(3'd0, 32'd1000, 32'd7, 5'd12);
`endif
    repeat (9) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("busy_after_abort", busy, 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", n_done - nd, 0);
    issue(3'd3, 32'hDEADBEEF, 32'h12345678, 5'd13); wait_idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
